// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   - access-size encoding carried in mem_mem_type
//   - FSM state encoding
//   - captured-access record held while the bus transaction runs
//   - misalignment predicate used in IDLE
package lsu_pkg;

    localparam logic [2:0] MT_BYTE = 3'd0;
    localparam logic [2:0] MT_HALF = 3'd1;
    localparam logic [2:0] MT_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    // Everything about the access that must stay stable after the EX/MEM
    // register is free to move on. lo keeps the byte offset so the load
    // path can steer the returned word.
    typedef struct packed {
        logic        wen;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [2:0]  mtype;
        logic        is_unsigned;
        logic [1:0]  lo;
    } lsu_acc_t;

    // Bytes are never misaligned; any size code other than byte/half is
    // handled as a word.
    function automatic logic misaligned(input logic [2:0] mtype, input logic [1:0] lo);
        logic bad;
        case (mtype)
            MT_BYTE: bad = 1'b0;
            MT_HALF: bad = lo[0];
            default: bad = |lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for a 32-bit data bus. Purely combinational.
//   addr_lo     in  2   byte offset inside the word
//   mem_type    in  3   access size (byte/half/word, others = word)
//   is_unsigned in  1   zero-extend loads when 1
//   store_data  in  32  register value to be stored
//   rdata       in  32  word returned by memory
//   wdata       out 32  store data replicated into every candidate lane
//   wstrb       out 4   byte enables for the addressed lanes
//   load_data   out 32  selected lane, sign/zero extended
// The store and load paths are independent; the parent uses one instance
// for each and ignores the other half.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_type,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
        half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        wdata     = store_data;
        wstrb     = 4'b1111;
        load_data = rdata;
        case (mem_type)
            MT_BYTE: begin
                // Replicating the byte lets the strobe alone pick the lane.
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << addr_lo;
                load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            end
            MT_HALF: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            end
            default: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit for the RV32 five-stage pipeline.
// Takes the access from the EX/MEM register, runs one valid/ready request
// on the data bus, waits for the response and returns extended load data.
//   clk, rst_n            clock, async active-low reset
//   mem_alu_result        effective byte address
//   mem_rs2_data          store data
//   mem_mem_ren/_wen      load / store request (both set = load)
//   mem_mem_type          0 byte, 1 half, 2 word, others word
//   mem_mem_unsigned      zero-extend loads
//   req_valid/req_ready   request handshake
//   req_addr/_wen/_wdata/_wstrb  request fields, stable while REQ
//   rsp_valid/rsp_rdata   response (read data or write ack)
//   lsu_stall             hold upstream stages and EX/MEM
//   load_valid/load_data  one-cycle load result pulse
//   lsu_misalign          misaligned access seen in IDLE
// Sequence is IDLE -> REQ -> WAIT -> DONE -> IDLE. Stall covers IDLE (on
// detect), REQ and WAIT; it drops in DONE so EX/MEM advances on that edge
// and the same instruction is never picked up again.
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_rs2_data,
    input  logic              mem_mem_ren,
    input  logic              mem_mem_wen,
    input  logic [2:0]        mem_mem_type,
    input  logic              mem_mem_unsigned,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_wen,
    output logic [DATA_W-1:0] req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              lsu_stall,
    output logic              load_valid,
    output logic [DATA_W-1:0] load_data,
    output logic              lsu_misalign
);

    lsu_state_t state, state_nxt;
    lsu_acc_t   acc_q;

    logic        access;
    logic        is_store;
    logic        bad_align;
    logic        capture;
    logic        ld_capture;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic [31:0] unused_st_load;
    logic [31:0] unused_ld_wdata;
    logic [3:0]  unused_ld_wstrb;

    assign access    = mem_mem_ren | mem_mem_wen;
    // Load wins when both enables are set.
    assign is_store  = mem_mem_wen & ~mem_mem_ren;
    assign bad_align = misaligned(mem_mem_type, mem_alu_result[1:0]);

    // Store steering works on the live EX/MEM fields so the result can be
    // registered at detect time.
    lsu_align u_align_st (
        .addr_lo     (mem_alu_result[1:0]),
        .mem_type    (mem_mem_type),
        .is_unsigned (mem_mem_unsigned),
        .store_data  (mem_rs2_data),
        .rdata       ('0),
        .wdata       (st_wdata),
        .wstrb       (st_wstrb),
        .load_data   (unused_st_load)
    );

    // Load steering works on the captured access and the bus response.
    lsu_align u_align_ld (
        .addr_lo     (acc_q.lo),
        .mem_type    (acc_q.mtype),
        .is_unsigned (acc_q.is_unsigned),
        .store_data  ('0),
        .rdata       (rsp_rdata),
        .wdata       (unused_ld_wdata),
        .wstrb       (unused_ld_wstrb),
        .load_data   (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        lsu_stall    = 1'b0;
        lsu_misalign = 1'b0;
        req_valid    = 1'b0;
        load_valid   = 1'b0;
        capture      = 1'b0;
        ld_capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    if (bad_align) begin
                        // Trap is raised upstream; nothing goes on the bus.
                        lsu_misalign = 1'b1;
                    end else begin
                        lsu_stall = 1'b1;
                        capture   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                lsu_stall = 1'b1;
                if (req_ready) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                lsu_stall = 1'b1;
                if (rsp_valid) begin
                    ld_capture = ~acc_q.wen;
                    state_nxt  = ST_DONE;
                end
            end
            ST_DONE: begin
                load_valid = ~acc_q.wen;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            req_addr  <= '0;
            load_data <= '0;
        end else begin
            if (capture) begin
                req_addr          <= {mem_alu_result[ADDR_W-1:2], 2'b00};
                acc_q.wen         <= is_store;
                acc_q.wstrb       <= is_store ? st_wstrb : 4'b0000;
                acc_q.wdata       <= is_store ? st_wdata : 32'd0;
                acc_q.mtype       <= mem_mem_type;
                acc_q.is_unsigned <= mem_mem_unsigned;
                acc_q.lo          <= mem_alu_result[1:0];
            end
            if (ld_capture) load_data <= ld_data;
        end
    end

    assign req_wen   = acc_q.wen;
    assign req_wstrb = acc_q.wstrb;
    assign req_wdata = acc_q.wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed accesses driven against a reference model
// derived from byte arithmetic; one compare process checks the outputs
// every cycle, plus literal expectations for the listed scenarios.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_rs2_data = '0;
    logic        mem_mem_ren = 1'b0;
    logic        mem_mem_wen = 1'b0;
    logic [2:0]  mem_mem_type = '0;
    logic        mem_mem_unsigned = 1'b0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_rdata = '0;
    logic        lsu_stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        lsu_misalign;

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data),
        .mem_mem_ren(mem_mem_ren), .mem_mem_wen(mem_mem_wen),
        .mem_mem_type(mem_mem_type), .mem_mem_unsigned(mem_mem_unsigned),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .lsu_stall(lsu_stall), .load_valid(load_valid), .load_data(load_data),
        .lsu_misalign(lsu_misalign)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Expectations consumed by the compare process.
    bit          chk_en = 1'b0;
    logic        exp_stall, exp_rv, exp_mis, exp_lv, exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_ldata;
    logic [3:0]  exp_wstrb;

    // Observations gathered by the driver.
    int          stall_cnt, hs_cnt, rv_cnt, ld_cnt;
    logic [31:0] last_ld, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_wen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---- reference model: byte arithmetic on the access size ----
    function automatic int nbytes(input logic [2:0] mt);
        return (mt == 3'd0) ? 1 : (mt == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] size_mask(input int n);
        return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] mt, input logic uns);
        int n;
        logic [31:0] mask, v;
        n    = nbytes(mt);
        mask = size_mask(n);
        v    = (word >> (8 * (addr % 4))) & mask;
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] addr, input logic [2:0] mt);
        int n;
        n = nbytes(mt);
        return 4'((((1 << n) - 1) << (addr % 4)) & 15);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic [2:0] mt);
        int n;
        n = nbytes(mt);
        return (rs2 & size_mask(n)) * ((n == 1) ? 32'h0101_0101 : (n == 2) ? 32'h0001_0001 : 32'd1);
    endfunction

    function automatic bit m_misaligned(input logic [31:0] addr, input logic [2:0] mt);
        return (addr % nbytes(mt)) != 0;
    endfunction

    // ---- compare process ----
    always @(negedge clk) begin
        if (chk_en) begin
            check("lsu_stall", {31'd0, lsu_stall}, {31'd0, exp_stall});
            check("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
            check("lsu_misalign", {31'd0, lsu_misalign}, {31'd0, exp_mis});
            check("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
            if (exp_rv) begin
                check("req_addr", req_addr, exp_addr);
                check("req_wen", {31'd0, req_wen}, {31'd0, exp_wen});
                check("req_wstrb", {28'd0, req_wstrb}, {28'd0, exp_wstrb});
                if (exp_wen) check("req_wdata", req_wdata, exp_wdata);
            end
            if (exp_lv) check("load_data", load_data, exp_ldata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic exp_idle();
        exp_stall = 0; exp_rv = 0; exp_mis = 0; exp_lv = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (lsu_stall) stall_cnt++;
        if (req_valid) rv_cnt++;
        if (req_valid && req_ready) hs_cnt++;
        if (load_valid) begin ld_cnt++; last_ld = load_data; end
        if (req_valid) begin last_wdata = req_wdata; last_wstrb = req_wstrb; last_wen = req_wen; end
        @(posedge clk);
        #1;
    endtask

    // One access from detection to the cycle after DONE. rdy_dly/rsp_dly
    // add wait cycles; noisy drives stray rsp_valid/req_ready where the
    // unit must ignore them.
    task automatic access(input logic [31:0] a, input logic [31:0] rs2, input logic ren,
                          input logic wen, input logic [2:0] mt, input logic uns,
                          input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                          input bit noisy);
        stall_cnt = 0; hs_cnt = 0; rv_cnt = 0; ld_cnt = 0;
        mem_alu_result = a; mem_rs2_data = rs2; mem_mem_ren = ren; mem_mem_wen = wen;
        mem_mem_type = mt; mem_mem_unsigned = uns;
        req_ready = 1'b1; rsp_valid = noisy; rsp_rdata = ~rdata;
        exp_idle();
        if (m_misaligned(a, mt)) begin
            exp_mis = 1;
            cyc(); cyc();
        end else begin
            exp_stall = 1;
            cyc();
            exp_rv    = 1;
            exp_addr  = a & 32'hFFFF_FFFC;
            exp_wen   = wen & ~ren;
            exp_wstrb = exp_wen ? m_wstrb(a, mt) : 4'd0;
            exp_wdata = m_wdata(rs2, mt);
            for (int k = 0; k <= rdy_dly; k++) begin
                req_ready = (k == rdy_dly);
                cyc();
            end
            exp_rv = 0;
            for (int j = 0; j <= rsp_dly; j++) begin
                req_ready = noisy;
                rsp_valid = (j == rsp_dly);
                rsp_rdata = (j == rsp_dly) ? rdata : ~rdata;
                cyc();
            end
            rsp_valid = noisy; rsp_rdata = 32'h5A5A_A5A5;
            exp_stall = 0; exp_lv = ren; exp_ldata = m_load(rdata, a, mt, uns);
            cyc();
        end
        mem_mem_ren = 0; mem_mem_wen = 0; rsp_valid = 0; req_ready = 0;
        exp_idle();
        cyc();
    endtask

    initial begin
        exp_idle();
        exp_addr = '0; exp_wen = 0; exp_wdata = '0; exp_ldata = '0; exp_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst req_valid", {31'd0, req_valid}, 32'd0);
        check("rst req_wen", {31'd0, req_wen}, 32'd0);
        check("rst req_wstrb", {28'd0, req_wstrb}, 32'd0);
        check("rst req_addr", req_addr, 32'd0);
        check("rst req_wdata", req_wdata, 32'd0);
        check("rst load_valid", {31'd0, load_valid}, 32'd0);
        check("rst load_data", load_data, 32'd0);
        check("rst lsu_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst lsu_misalign", {31'd0, lsu_misalign}, 32'd0);
        rst_n = 1'b1;

        // Pin the model with hand-worked values.
        check("model sbyte", m_load(32'h8012_3456, 32'h8000_0003, MT_BYTE, 1'b0), 32'hFFFF_FF80);
        check("model ubyte", m_load(32'h8012_3456, 32'h8000_0003, MT_BYTE, 1'b1), 32'h0000_0080);
        check("model shalf", m_load(32'h8001_1234, 32'h8000_0002, MT_HALF, 1'b0), 32'hFFFF_8001);
        check("model wstrb", {28'd0, m_wstrb(32'h8000_0001, MT_BYTE)}, 32'h2);
        check("model wdata", m_wdata(32'h1234_56AB, MT_BYTE), 32'hABAB_ABAB);

        chk_en = 1'b1;
        cyc(); cyc();

        // Word load, minimum latency.
        access(32'h8000_0004, 32'h0, 1, 0, MT_WORD, 0, 32'hDEAD_BEEF, 0, 0, 0);
        check("wl stall cycles", stall_cnt, 3);
        check("wl load_data", last_ld, 32'hDEAD_BEEF);
        check("wl wstrb", {28'd0, last_wstrb}, 32'h0);
        check("wl handshakes", hs_cnt, 1);

        // Byte/half extension.
        access(32'h8000_0003, 32'h0, 1, 0, MT_BYTE, 0, 32'h8012_3456, 0, 0, 0);
        check("sbyte", last_ld, 32'hFFFF_FF80);
        access(32'h8000_0003, 32'h0, 1, 0, MT_BYTE, 1, 32'h8012_3456, 0, 0, 0);
        check("ubyte", last_ld, 32'h0000_0080);
        access(32'h8000_0002, 32'h0, 1, 0, MT_HALF, 0, 32'h8001_1234, 0, 0, 0);
        check("shalf", last_ld, 32'hFFFF_8001);

        // Byte store.
        access(32'h8000_0001, 32'h1234_56AB, 0, 1, MT_BYTE, 0, 32'h0, 0, 0, 0);
        check("bst wdata", last_wdata, 32'hABAB_ABAB);
        check("bst wstrb", {28'd0, last_wstrb}, 32'h2);
        check("bst wen", {31'd0, last_wen}, 32'd1);
        check("bst no load_valid", ld_cnt, 0);

        // Backpressure on both sides, stray response/ready noise.
        access(32'h8000_0010, 32'hCAFE_F00D, 0, 1, MT_WORD, 0, 32'h0, 4, 3, 1);
        check("bp handshakes", hs_cnt, 1);
        check("bp stall cycles", stall_cnt, 10);
        access(32'h8000_0006, 32'h0, 1, 0, MT_HALF, 1, 32'hBEEF_1234, 2, 1, 1);
        check("bp uhalf", last_ld, 32'h0000_BEEF);
        check("bp ld handshakes", hs_cnt, 1);

        // Misaligned accesses never reach the bus.
        access(32'h8000_0002, 32'h0, 1, 0, MT_WORD, 0, 32'h0, 0, 0, 0);
        check("mis word req", rv_cnt, 0);
        check("mis word stall", stall_cnt, 0);
        access(32'h8000_0005, 32'h55AA, 0, 1, MT_HALF, 0, 32'h0, 0, 0, 0);
        check("mis half req", rv_cnt, 0);

        // Lane sweeps, size code 3 as word, load priority over store.
        for (int off = 0; off < 4; off++) begin
            access(32'h0000_0100 + off, 32'hA1B2_C3D4, 0, 1, MT_BYTE, 0, 32'h0, 0, 0, 0);
            access(32'h0000_0100 + off, 32'h0, 1, 0, MT_BYTE, 0, 32'h8F7F_01FE, 0, 1, 0);
        end
        access(32'h0000_0100, 32'hA1B2_C3D4, 0, 1, MT_HALF, 0, 32'h0, 0, 0, 0);
        access(32'h0000_0102, 32'hA1B2_C3D4, 0, 1, MT_HALF, 0, 32'h0, 1, 0, 0);
        access(32'h0000_0100, 32'h0, 1, 0, MT_HALF, 0, 32'h1234_F00D, 0, 0, 0);
        access(32'h0000_0104, 32'h0, 1, 0, 3'd3, 0, 32'h0BAD_F00D, 0, 0, 0);
        check("mt3 load", last_ld, 32'h0BAD_F00D);
        access(32'h0000_0200, 32'h7777_7777, 1, 1, MT_WORD, 0, 32'h1357_9BDF, 0, 0, 0);
        check("ren+wen is load", {31'd0, last_wen}, 32'd0);
        check("ren+wen data", last_ld, 32'h1357_9BDF);

        // Reset while waiting for the response.
        chk_en = 1'b0;
        mem_alu_result = 32'h8000_0008; mem_mem_type = MT_WORD; mem_mem_ren = 1;
        mem_mem_unsigned = 0; req_ready = 1;
        cyc(); cyc();
        check("pre-rst stall", {31'd0, lsu_stall}, 32'd1);
        rst_n = 1'b0; mem_mem_ren = 0; req_ready = 0;
        rsp_valid = 1; rsp_rdata = 32'h1234_5678;
        #1;
        check("mid-rst req_valid", {31'd0, req_valid}, 32'd0);
        check("mid-rst load_valid", {31'd0, load_valid}, 32'd0);
        check("mid-rst stall", {31'd0, lsu_stall}, 32'd0);
        cyc(); cyc();
        check("mid-rst load_data", load_data, 32'd0);
        rst_n = 1'b1;
        exp_idle();
        chk_en = 1'b1;
        cyc();
        rsp_valid = 0;
        cyc();
        access(32'h8000_000C, 32'h0, 1, 0, MT_WORD, 0, 32'hFEED_FACE, 0, 0, 0);
        check("post-rst load", last_ld, 32'hFEED_FACE);
        check("post-rst stall", stall_cnt, 3);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
